// File: rtl/comprobador_funcion.sv
// Response checker for an exhaustive 3-input sweep: samples {X,Y,Z,F}, compares F with TABLA.
// Latency: results register one cycle after the sample; done/pass rise the cycle after the completing sample.
// No backpressure: every valid sample in RUN is consumed. Optional feature macro: STRICT_ORDER_EN.
module comprobador_funcion #(
  parameter logic [7:0] TABLA = 8'b1110_1000,
  parameter int         ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             valid,
  input  logic             X,
  input  logic             Y,
  input  logic             Z,
  input  logic             F,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       cov,
  output logic [ERR_W-1:0] err_cnt,
  output logic             err_valid,
  output logic [2:0]       err_idx,
  output logic             err_f
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    RUN    = 2'b01,
    PASS_S = 2'b10,
    FAIL_S = 2'b11
  } state_t;

  localparam logic [ERR_W-1:0] ERR_MAX = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] ERR_ONE = {{(ERR_W-1){1'b0}}, 1'b1};

  state_t     state;
  logic [2:0] idx;
  logic       in_order;
  logic       mismatch;
  logic [7:0] cov_new;
  logic       complete;

  assign idx = {X, Y, Z};

`ifdef STRICT_ORDER_EN
  // Expected index of the next in-order sample.
  logic [2:0] next_idx;
  assign in_order = (idx == next_idx);
`else
  assign in_order = 1'b1;
`endif

  // An out-of-order sample is always an error and never earns coverage.
  assign mismatch = (F != TABLA[idx]) || !in_order;
  assign cov_new  = in_order ? (cov | (8'b0000_0001 << idx)) : cov;
  assign complete = (cov_new == 8'hFF);

  // Run control, coverage, error capture and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      cov       <= 8'h00;
      err_cnt   <= '0;
      err_valid <= 1'b0;
      err_idx   <= 3'b000;
      err_f     <= 1'b0;
`ifdef STRICT_ORDER_EN
      next_idx  <= 3'b000;
`endif
    end else if (start) begin
      // A sample coinciding with start is deliberately dropped.
      state     <= RUN;
      busy      <= 1'b1;
      done      <= 1'b0;
      pass      <= 1'b0;
      cov       <= 8'h00;
      err_cnt   <= '0;
      err_valid <= 1'b0;
      err_idx   <= 3'b000;
      err_f     <= 1'b0;
`ifdef STRICT_ORDER_EN
      next_idx  <= 3'b000;
`endif
    end else if (state == RUN && valid) begin
      cov <= cov_new;
      if (mismatch) begin
        if (err_cnt != ERR_MAX) begin
          err_cnt <= err_cnt + ERR_ONE;
        end
        if (!err_valid) begin
          err_valid <= 1'b1;
          err_idx   <= idx;
          err_f     <= F;
        end
      end
`ifdef STRICT_ORDER_EN
      if (in_order) begin
        next_idx <= next_idx + 3'b001;
      end
`endif
      if (complete) begin
        // pass is decided by whether any error was ever captured, not by the counter.
        busy <= 1'b0;
        done <= 1'b1;
        if (err_valid || mismatch) begin
          state <= FAIL_S;
          pass  <= 1'b0;
        end else begin
          state <= PASS_S;
          pass  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_comprobador_funcion.sv
// Randomized + directed bench for comprobador_funcion against a behavioural model (majority function).
// Model updates on posedge from the driven inputs; a single compare process checks every output on negedge.
// Directed phases pin the model with hand-computed literals before a long random phase.
module tb_comprobador_funcion;

  localparam int ERR_W = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             valid = 1'b0;
  logic             X = 1'b0;
  logic             Y = 1'b0;
  logic             Z = 1'b0;
  logic             F = 1'b0;
  logic             busy;
  logic             done;
  logic             pass;
  logic [7:0]       cov;
  logic [ERR_W-1:0] err_cnt;
  logic             err_valid;
  logic [2:0]       err_idx;
  logic             err_f;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  comprobador_funcion #(.ERR_W(ERR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid),
    .X(X), .Y(Y), .Z(Z), .F(F),
    .busy(busy), .done(done), .pass(pass), .cov(cov),
    .err_cnt(err_cnt), .err_valid(err_valid), .err_idx(err_idx), .err_f(err_f)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Phase of the run: 0 idle, 1 running, 2 passed, 3 failed.
  int m_phase = 0;
  bit m_seen[8];
  int m_errors = 0;
  bit m_have_first = 0;
  int m_first_idx = 0;
  int m_first_f = 0;
  int m_expect_next = 0;

  function automatic int majority(input int x, input int y, input int z);
    return ((x + y + z) >= 2) ? 1 : 0;
  endfunction

  function automatic int seen_count();
    int c = 0;
    for (int i = 0; i < 8; i++) c += m_seen[i];
    return c;
  endfunction

  function automatic logic [7:0] seen_map();
    logic [7:0] m = 8'h00;
    for (int i = 0; i < 8; i++) m[i] = m_seen[i];
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) m_seen[i] = 1'b0;
    m_errors = 0;
    m_have_first = 0;
    m_first_idx = 0;
    m_first_f = 0;
    m_expect_next = 0;
  endtask

  always @(posedge clk) begin
    int i;
    bit bad;
    bit accept;
    if (rst) begin
      m_phase = 0;
      model_clear();
    end else if (start) begin
      m_phase = 1;
      model_clear();
    end else if (m_phase == 1 && valid) begin
      i = X * 4 + Y * 2 + Z;
      accept = 1'b1;
`ifdef STRICT_ORDER_EN
      accept = (i == m_expect_next);
`endif
      bad = (int'(F) != majority(X, Y, Z)) || !accept;
      if (accept) begin
        m_seen[i] = 1'b1;
        m_expect_next = (m_expect_next + 1) % 8;
      end
      if (bad) begin
        m_errors++;
        if (!m_have_first) begin
          m_have_first = 1;
          m_first_idx = i;
          m_first_f = F;
        end
      end
      if (seen_count() == 8) m_phase = m_have_first ? 3 : 2;
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    int sat;
    if (chk_en) begin
      sat = (m_errors > (1 << ERR_W) - 1) ? (1 << ERR_W) - 1 : m_errors;
      chk("busy", busy, m_phase == 1);
      chk("done", done, m_phase >= 2);
      chk("pass", pass, m_phase == 2);
      chk("cov", cov, seen_map());
      chk("err_cnt", err_cnt, sat);
      chk("err_valid", err_valid, m_have_first);
      chk("err_idx", err_idx, m_first_idx);
      chk("err_f", err_f, m_first_f);
    end
  end

  // ---------------- stimulus helpers (all on negedge) ----------------
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sample(input int idx, input bit f, input int gap);
    {X, Y, Z} = idx[2:0];
    F = f;
    valid = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic bit good_f(input int idx);
    return majority(idx / 4 % 2, idx / 2 % 2, idx % 2) != 0;
  endfunction

  initial begin
    // T1: reset for two clocks.
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("t1_busy", busy, 0);
    chk("t1_done", done, 0);
    chk("t1_cov", cov, 8'h00);
    chk("t1_err_cnt", err_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    // T2: clean sweep, samples spaced out.
    do_start();
    for (int i = 0; i < 8; i++) sample(i, good_f(i), (i == 7) ? 0 : 9);
    chk("t2_done", done, 1);
    chk("t2_pass", pass, 1);
    chk("t2_cov", cov, 8'hFF);
    chk("t2_err_cnt", err_cnt, 0);

    // T3: F wrong at index 5 (majority gives 1 there).
    do_start();
    for (int i = 0; i < 8; i++) sample(i, (i == 5) ? 1'b0 : good_f(i), 0);
    chk("t3_done", done, 1);
    chk("t3_pass", pass, 0);
    chk("t3_err_cnt", err_cnt, 1);
    chk("t3_err_idx", err_idx, 3'b101);
    chk("t3_err_f", err_f, 0);

    // T4: seven distinct indices plus a duplicate, then the last one.
    do_start();
    for (int i = 0; i < 7; i++) sample(i, good_f(i), 0);
    sample(0, good_f(0), 0);
    chk("t4_busy", busy, 1);
    chk("t4_done", done, 0);
    chk("t4_cov", cov, 8'h7F);
    sample(7, good_f(7), 0);
    chk("t4_pass", pass, 1);

    // T5: 21 wrong samples over indices 0..6, then wrong index 7 -> counter saturates.
    do_start();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 7; i++) sample(i, !good_f(i), 0);
    chk("t5_busy", busy, 1);
    sample(7, !good_f(7), 0);
    chk("t5_err_cnt", err_cnt, 4'hF);
    chk("t5_err_idx", err_idx, 0);
    chk("t5_err_f", err_f, 1);
    chk("t5_fail", {done, pass}, 2'b10);

    // T6: reset mid-run, then start with a coincident sample that must be dropped.
    do_start();
    for (int i = 0; i < 4; i++) sample(i, !good_f(i), 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t6_cov_rst", cov, 8'h00);
    chk("t6_err_cnt_rst", err_cnt, 0);
    chk("t6_busy_rst", busy, 0);
    start = 1'b1;
    valid = 1'b1;
    {X, Y, Z} = 3'b011;
    F = 1'b0;
    @(negedge clk);
    start = 1'b0;
    valid = 1'b0;
    chk("t6_cov_start", cov, 8'h00);
    chk("t6_busy_start", busy, 1);
    chk("t6_err_valid", err_valid, 0);

    // Random phase: mostly-correct F, rare start/rst, random valid and index.
    for (int c = 0; c < 4000; c++) begin
      int r;
      int idx;
      r = $urandom_range(0, 199);
      rst = (r == 0);
      start = (r >= 1 && r <= 3);
      valid = $urandom_range(0, 1);
      idx = $urandom_range(0, 7);
      {X, Y, Z} = idx[2:0];
      F = ($urandom_range(0, 15) == 0) ? !good_f(idx) : good_f(idx);
      @(negedge clk);
    end
    rst = 1'b0;
    start = 1'b0;
    valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
